// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and
// the frame delimiters used by the downstream frame buffer.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [7:0] START_FRAME = 8'hAA;
  localparam logic [7:0] END_FRAME   = 8'h55;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs; both flops reset
// to RST_VAL so an idle-high line shows no spurious edge after reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: samples mid-bit, strobes rx_done on a good stop bit and
// frame_err on a bad one, and filters start-bit glitches shorter than half a bit.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int CNT_W       = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_e      state_q,   state_d;
  logic [CNT_W-1:0] timer_q,   timer_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic [7:0]       byte_q,    byte_d;
  logic             done_q,    done_d;
  logic             err_q,     err_d;
  logic             rx_prev_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s && rx_prev_q) begin
          state_d = ST_START;
          timer_d = '0;
        end
      end
      // A start bit that has gone high again by mid-bit is treated as noise.
      ST_START: begin
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          if (!rx_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d           = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      byte_q    <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rx_prev_q <= rx_s;
    end
  end

  assign rx_byte   = byte_q;
  assign rx_done   = done_q;
  assign frame_err = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at 8 clocks per bit: stimulus pushes the
// expected strobe, a forked monitor pops and compares on every strobe.
module tb_uart_rx_byte;

  localparam int CPB = 8;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  typedef struct {
    bit         isErr;
    logic [7:0] data;
  } exp_t;

  exp_t       expQ[$];
  int         compareCount;
  int         failCount;
  int         busyCycles;
  logic [7:0] lastGood;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitBit();
    repeat (CPB) @(negedge clk);
  endtask

  // Sends one 8N1 frame and records the strobe it should produce.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    exp_t e;
    if (stopBit) begin
      e.isErr  = 1'b0;
      e.data   = data;
      lastGood = data;
    end else begin
      e.isErr = 1'b1;
      e.data  = lastGood;
    end
    expQ.push_back(e);
    rx = 1'b0;
    waitBit();
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      waitBit();
    end
    rx = stopBit;
    waitBit();
  endtask

  task automatic runMonitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busyCycles++;
      if (rx_done === 1'b1 || frame_err === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_strobe", int'({rx_done, frame_err}), 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("strobe_kind", int'({rx_done, frame_err}),
                      e.isErr ? 1 : 2);
          checkOutput("strobe_byte", int'(rx_byte), int'(e.data));
        end
      end
    end
  endtask

  initial begin
    int b0;
    compareCount = 0;
    failCount    = 0;
    busyCycles   = 0;
    lastGood     = 8'h00;
    rst_n        = 1'b0;
    rx           = 1'b1;
    fork
      runMonitor();
    join_none

    repeat (5) @(negedge clk);
    checkOutput("reset_rx_byte", int'(rx_byte), 0);
    checkOutput("reset_rx_done", int'(rx_done), 0);
    checkOutput("reset_frame_err", int'(frame_err), 0);
    checkOutput("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single frame, with exact busy duration.
    b0 = busyCycles;
    applyStimulus(8'hAA, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("busy_cycles_frame", busyCycles - b0, CPB / 2 + 9 * CPB);
    checkOutput("busy_idle_after", int'(busy), 0);

    // Back-to-back frames without idle gap.
    applyStimulus(8'hAA, 1'b1);
    applyStimulus(8'h10, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'h55, 1'b1);
    repeat (20) @(negedge clk);

    // Start-bit glitch of two cycles.
    b0 = busyCycles;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("glitch_busy_cycles", busyCycles - b0, CPB / 2);
    checkOutput("glitch_busy_idle", int'(busy), 0);

    // Bad stop bit keeps the previous good byte.
    applyStimulus(8'hAA, 1'b1);
    repeat (10) @(negedge clk);
    applyStimulus(8'h55, 1'b0);
    rx = 1'b1;
    waitBit();
    applyStimulus(8'h11, 1'b1);
    repeat (10) @(negedge clk);

    // Break: 40 bit-times low gives one frame error.
    begin
      exp_t e;
      e.isErr = 1'b1;
      e.data  = lastGood;
      expQ.push_back(e);
    end
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    applyStimulus(8'h69, 1'b1);
    repeat (10) @(negedge clk);

    // Reset during data bit 4; remaining bits are high so no edge follows.
    rx = 1'b0;
    waitBit();
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0) ? 1'b1 : 1'b0;
      waitBit();
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_rx_byte", int'(rx_byte), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_rx_done", int'(rx_done), 0);
    rst_n    = 1'b1;
    lastGood = 8'h00;
    repeat (5 * CPB) @(negedge clk);
    checkOutput("midreset_no_frame_busy", int'(busy), 0);
    applyStimulus(8'hC3, 1'b1);
    repeat (40) @(negedge clk);

    checkOutput("pending_expectations", expQ.size(), 0);
    checkOutput("final_rx_byte", int'(rx_byte), 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
UART byte receiver that sits directly upstream of the PID frame buffer.
- Recovers 8N1 frames from the asynchronous `rx` pin.
- Presents each good byte on `rx_byte` with a one-cycle `rx_done` strobe, which is the exact interface the frame buffer consumes.
- Flags framing errors and rejects start-bit glitches so that line noise never reaches the frame parser.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); legal range 4..65535
CNT_W, $clog2(CLKS_PER_BIT), bit-timer width; derived, not overridden

Ports:
clk        in   1  system clock, all logic on rising edge
rst_n      in   1  reset, synchronous, active-low
rx         in   1  asynchronous serial input, idle high
rx_byte    out  8  last correctly received byte, LSB-first reassembled
rx_done    out  1  one-cycle pulse, rx_byte valid and new
frame_err  out  1  one-cycle pulse, stop bit sampled low
busy       out  1  high while a frame is in progress (any state but IDLE)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rx_byte=8'h00, rx_done=0, frame_err=0, busy=0, state=IDLE.
  - Bit timer and bit index are 0.
  - Both synchronizer flops reset to 1, so no false start after reset.
  - Reset mid-frame aborts the frame silently: no rx_done, no frame_err.
- Input conditioning: `rx` passes through a 2-FF synchronizer; the FSM sees only `rx_s`. Edge detection compares `rx_s` with a third registered copy.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on a falling edge of rx_s, go to START and clear the timer.
  - START: count to CLKS_PER_BIT/2-1 (integer division), then sample rx_s.
    - If 0: go to DATA, bit index=0, timer cleared.
    - If 1: glitch, return to IDLE with no output.
  - DATA: count to CLKS_PER_BIT-1, then sample rx_s into shift[bit index] (LSB first).
    - Bit index 0..7; after index 7, go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample.
    - If 1: rx_byte <= shift, rx_done=1 for exactly one cycle, go to IDLE.
    - If 0: frame_err=1 for one cycle, rx_byte unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: remain until rx_s==1, then go to IDLE. A held-low break yields exactly one frame_err.
- Timing:
  - Stop-bit sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the falling edge is seen in IDLE.
  - rx_done/frame_err are registered and asserted in the cycle following that sample.
  - Total pin-to-strobe latency adds 2 cycles of synchronizer delay.
- rx_byte holds its value between strobes and is stable in the rx_done cycle and after it.
- rx_done and frame_err are never high in the same cycle.
- Back-to-back frames: the transition to IDLE happens mid stop bit, so a start edge arriving at the nominal stop-bit end is caught. There are zero dead cycles beyond half a bit.
- Timer wrap: the timer is cleared on every sample. It never free-runs past CLKS_PER_BIT-1.
- No parity, no FIFO. There is no overrun condition, because the downstream stage consumes each rx_done pulse combinationally.

Decomposition:
- Shared package uart_pkg:
  - FSM state localparams (3-bit encoding).
  - Default CLKS_PER_BIT.
  - Frame constants START_FRAME=8'hAA and END_FRAME=8'h55, for benches and the frame buffer.
- One natural sub-module: sync_2ff (two flops, reset value parameter RST_VAL=1), reused for other async pins.

Test Plan (CLKS_PER_BIT=8 for speed):
- Drive 8N1 byte 8'hAA after reset → exactly one rx_done, rx_byte=8'hAA, frame_err never high, busy high for ~76 cycles then 0.
- Back-to-back frames 8'hAA, 8'h10, 8'h3C, 8'h55 with no idle gap → four rx_done pulses in order with matching rx_byte. Feeding these into the frame buffer gives a1_bytes[3]=8'h3C.
- Pull rx low for 2 cycles, then high → busy pulses, returns to IDLE, no rx_done, no frame_err.
- Send 8'h55 with stop bit forced 0, previous byte 8'hAA → one frame_err pulse, no rx_done, rx_byte stays 8'hAA. A following good 8'h11 gives rx_done with rx_byte=8'h11.
- Hold rx low for 40 bit-times (break), then release and send 8'h69 → exactly one frame_err during the break, then rx_done with rx_byte=8'h69.
- Assert rst_n=0 for 1 cycle at data bit 4 of a frame → outputs return to reset values, no strobe for the aborted frame. The next clean 8'hC3 is received correctly.
